sort_frame_collector: RTL and testbench
=======================================

Name: sort_frame_collector

Overview:
- Upstream neighbour of the five-lane compare-exchange sorting stages.
- Accepts a serial byte stream over a valid/ready handshake and assembles frames of five 8-bit values.
- Pads short frames with a configurable value and presents the five lanes in parallel, held stable, to the first sorting stage until the consumer accepts.
- Keeps a count of real elements per frame and a running frame counter.

Parameters:
WIDTH, 8, bit width of each element
PAD_VALUE, 8'hFF, fill value for unused lanes of a short frame; all-ones makes pads sort to the top
CNT_WIDTH, 16, width of the frame counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous and active-low
in_data  input  WIDTH  element being offered
in_valid  input  1  in_data is valid this cycle
in_last  input  1  qualifies in_data as the final element of the frame; sampled only on an accepted beat
in_ready  output  1  collector can accept this cycle
a0..a4  output  WIDTH each  frame lanes; a0 holds the first element received
out_count  output  3  number of real elements in the frame presented, 1..5
out_valid  output  1  a0..a4 and out_count form a complete frame
out_ready  input  1  downstream accepts the frame
frame_cnt  output  CNT_WIDTH  frames handed off since reset

Behaviour:
- One clock domain. All state changes on the rising edge of clk.
- Reset (rst_n low at an edge):
  - state goes to FILL; write index idx goes to 0.
  - a0..a4, out_count, out_valid and frame_cnt all go to 0.
  - in_ready is forced to 0 while rst_n is low.
  - Reset mid-frame discards every partially collected element, with no output.
- An accept occurs when in_valid and in_ready are both high at a clock edge.
- State FILL:
  - in_ready = 1; out_valid = 0.
  - On an accept, in_data is written to lane idx.
  - If idx == 4, or in_last is 1: lanes idx+1..4 are loaded with PAD_VALUE in the same edge, out_count <= idx+1, and state goes to HOLD.
  - Otherwise idx increments and state stays FILL.
  - in_last on the 5th element behaves exactly like a full frame with no in_last.
- State HOLD:
  - in_ready = 0; out_valid = 1.
  - a0..a4 and out_count are held constant.
  - When out_ready is 1 at an edge: frame_cnt increments, idx goes to 0, state returns to FILL, out_valid drops the next cycle.
  - Lane contents are left unchanged on return to FILL and are overwritten as new data arrives.
- Lane and count outputs are driven from registers only; no combinational path from in_data to the a outputs.
- Latency: out_valid rises on the edge that accepts the final element of the frame and is visible the cycle after that accept.
- Throughput: with out_ready tied high, HOLD lasts one cycle, giving at most one frame every 6 cycles for 5-element frames.
- out_ready while in FILL is ignored. in_valid and in_last while in HOLD are ignored; the upstream source holds its data.
- in_valid low between beats creates gaps that do not affect collection; idx is preserved.
- frame_cnt wraps from 2^CNT_WIDTH-1 to 0 silently.
- States: FILL, HOLD, encoded in one bit.
- No outputs are X after the first reset edge.

Test Plan:
- Reset then stream 8'h37,8'h05,8'hC2,8'h10,8'h9A with in_valid high every cycle -> 5 accepts; next cycle out_valid=1, a0..a4=37,05,C2,10,9A, out_count=5, in_ready=0; out_ready=1 for one cycle -> frame_cnt=1, in_ready=1 the following cycle.
- Short frame: 8'h44, then 8'h02 with in_last=1 -> a0..a4=44,02,FF,FF,FF, out_count=2; single element with in_last=1 -> out_count=1, a1..a4=FF.
- Backpressure: complete a frame while out_ready=0 for 7 cycles with in_valid held high and in_data changing -> lanes stable, in_ready=0 for all 7 cycles, no element consumed; release out_ready -> the next frame starts with the held in_data as a0.
- Gapped input: 5 elements with in_valid toggling 1,0,0,1,... -> same lanes as the contiguous case; out_valid only after the 5th accept.
- Reset mid-frame: accept 3 elements, pull rst_n low for one edge, then send 5 new elements -> the frame contains only the new 5, out_count=5, frame_cnt counts from 0.
- Counter wrap with CNT_WIDTH=2: hand off 5 frames -> frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/sort_frame_collector.sv
`default_nettype none
// ============================================================================
// Module      : sort_frame_collector
// Description : Collects a serial valid/ready byte stream into frames of five
//               lanes for the five-lane compare-exchange sorter. Short frames
//               (terminated by in_last) are padded with PAD_VALUE. A complete
//               frame is held stable on a0..a4 until out_ready is seen.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               in_data/in_valid/
//               in_last/in_ready      - upstream element stream
//               a0..a4, out_count     - registered frame lanes / real count
//               out_valid/out_ready   - downstream frame handshake
//               frame_cnt             - frames handed off since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module sort_frame_collector #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   PAD_VALUE = 8'hFF,
  parameter int                 CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     a0,
  output logic [WIDTH-1:0]     a1,
  output logic [WIDTH-1:0]     a2,
  output logic [WIDTH-1:0]     a3,
  output logic [WIDTH-1:0]     a4,
  output logic [2:0]           out_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] frame_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [2:0] C_LAST_IDX = 3'd4;

  state_t                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic [4:0][WIDTH-1:0]    lane_q, lane_d;
  logic [2:0]               count_q, count_d;
  logic [CNT_WIDTH-1:0]     fcnt_q, fcnt_d;
  logic                     w_accept;

  // in_ready also gated by rst_n so nothing is taken while reset is asserted.
  assign in_ready  = rst_n && (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    count_d = count_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      FILL: begin
        if (w_accept) begin
          lane_d[idx_q] = in_data;
          if ((idx_q == C_LAST_IDX) || in_last) begin
            // Pad every lane above the final element in the same edge, so the
            // frame is complete the cycle out_valid rises.
            for (int i = 0; i < 5; i++) begin
              if (3'(i) > idx_q) begin
                lane_d[i] = PAD_VALUE;
              end
            end
            count_d = idx_q + 3'd1;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          fcnt_d  = fcnt_q + 1'b1;
          idx_d   = 3'd0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= 3'd0;
      lane_q  <= '0;
      count_q <= 3'd0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      count_q <= count_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign a0        = lane_q[0];
  assign a1        = lane_q[1];
  assign a2        = lane_q[2];
  assign a3        = lane_q[3];
  assign a4        = lane_q[4];
  assign out_count = count_q;
  assign frame_cnt = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_frame_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_frame_collector
// Description : Scoreboard bench for sort_frame_collector. Stimulus pushes the
//               expected frame before sending its final element; a monitor
//               pops and compares at every frame handoff. A second instance
//               with a 2-bit frame counter exercises wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_frame_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [7:0]  a0, a1, a2, a3, a4;
  logic [2:0]  out_count;
  logic [15:0] frame_cnt;

  logic        w_in_ready, w_out_valid;
  logic [7:0]  w_a0, w_a1, w_a2, w_a3, w_a4;
  logic [2:0]  w_out_count;
  logic [1:0]  w_frame_cnt;

  always #5 clk = ~clk;

  sort_frame_collector #(.WIDTH(8), .PAD_VALUE(8'hFF), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .a0(a0), .a1(a1), .a2(a2),
    .a3(a3), .a4(a4), .out_count(out_count), .out_valid(out_valid),
    .out_ready(out_ready), .frame_cnt(frame_cnt)
  );

  sort_frame_collector #(.WIDTH(8), .PAD_VALUE(8'hFF), .CNT_WIDTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(w_in_ready), .a0(w_a0), .a1(w_a1), .a2(w_a2),
    .a3(w_a3), .a4(w_a4), .out_count(w_out_count), .out_valid(w_out_valid),
    .out_ready(out_ready), .frame_cnt(w_frame_cnt)
  );

  typedef struct {
    logic [39:0] lanes;
    logic [2:0]  cnt;
    logic [15:0] fcnt;
    logic [1:0]  wcnt;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3, input logic [7:0] e4, input logic [2:0] c,
                           input logic [15:0] f, input logic [1:0] w);
    frame_t fr;
    fr.lanes = {e0, e1, e2, e3, e4};
    fr.cnt   = c;
    fr.fcnt  = f;
    fr.wcnt  = w;
    exp_q.push_back(fr);
  endtask

  // Monitor: compares lanes at the handoff, counters the cycle after.
  initial begin
    frame_t cur;
    logic   pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) begin
        chk("frame_cnt", 64'(frame_cnt), 64'(cur.fcnt));
        chk("frame_cnt_wrap", 64'(w_frame_cnt), 64'(cur.wcnt));
        pending = 1'b0;
      end
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 64'(1), 64'(0));
        end else begin
          cur = exp_q.pop_front();
          chk("lanes", 64'({a0, a1, a2, a3, a4}), 64'(cur.lanes));
          chk("out_count", 64'(out_count), 64'(cur.cnt));
          pending = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int   n = 0;
    logic r;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 64'(1), 64'(0));
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("rst_lanes_count", 64'({a0, a1, a2, a3, a4, out_count}), 64'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset and a contiguous full frame held until a single out_ready pulse.
    do_reset();
    exp_frame(8'h37, 8'h05, 8'hC2, 8'h10, 8'h9A, 3'd5, 16'd1, 2'd1);
    send(8'h37, 1'b0); send(8'h05, 1'b0); send(8'hC2, 1'b0);
    send(8'h10, 1'b0); send(8'h9A, 1'b0);
    chk("full_out_valid", 64'(out_valid), 64'(1));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("after_handoff_in_ready", 64'(in_ready), 64'(1));
    chk("after_handoff_out_valid", 64'(out_valid), 64'(0));

    // Short frames: two elements, then one.
    out_ready = 1'b1;
    exp_frame(8'h44, 8'h02, 8'hFF, 8'hFF, 8'hFF, 3'd2, 16'd2, 2'd2);
    send(8'h44, 1'b0); send(8'h02, 1'b1);
    exp_frame(8'h77, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd1, 16'd3, 2'd3);
    send(8'h77, 1'b1);
    drain();

    // Backpressure: frame held for 7 cycles with upstream still offering data.
    out_ready = 1'b0;
    exp_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 3'd5, 16'd4, 2'd0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    send(8'h44, 1'b0); send(8'h55, 1'b0);
    for (int i = 0; i < 7; i++) begin
      in_data  = 8'hA0 + 8'(i);
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_lanes", 64'({a0, a1, a2, a3, a4}), 64'h11_22_33_44_55);
      @(posedge clk);
      #1;
    end
    exp_frame(8'hA6, 8'h01, 8'h02, 8'h03, 8'h04, 3'd5, 16'd5, 2'd1);
    out_ready = 1'b1;
    send(8'hA6, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
    send(8'h03, 1'b0); send(8'h04, 1'b0);
    drain();

    // Gapped input.
    exp_frame(8'h37, 8'h05, 8'hC2, 8'h10, 8'h9A, 3'd5, 16'd6, 2'd2);
    send(8'h37, 1'b0); idle(2);
    send(8'h05, 1'b0); idle(2);
    send(8'hC2, 1'b0); idle(2);
    send(8'h10, 1'b0); idle(2);
    chk("gap_no_early_valid", 64'(out_valid), 64'(0));
    send(8'h9A, 1'b0);
    drain();

    // Reset mid-frame discards the partial frame.
    send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0);
    do_reset();
    exp_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 3'd5, 16'd1, 2'd1);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    send(8'h04, 1'b0); send(8'h05, 1'b0);
    drain();

    // Counter wrap on the 2-bit instance: 1,2,3,0,1.
    do_reset();
    exp_frame(8'hC1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd1, 16'd1, 2'd1);
    send(8'hC1, 1'b1);
    exp_frame(8'hC2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd1, 16'd2, 2'd2);
    send(8'hC2, 1'b1);
    exp_frame(8'hC3, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd1, 16'd3, 2'd3);
    send(8'hC3, 1'b1);
    exp_frame(8'hC4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd1, 16'd4, 2'd0);
    send(8'hC4, 1'b1);
    exp_frame(8'hC5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd1, 16'd5, 2'd1);
    send(8'hC5, 1'b1);
    drain();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
